// File: rtl/mitll_not_sched.sv
// mitll_not_sched: round-robin scheduler sharing one clocked RSFQ NOT cell among requesters
module mitll_not_sched #(
    parameter int N_REQ       = 4,
    parameter int INIT_WAIT   = 8,
    parameter int A_CLK_GAP   = 2,
    parameter int CLK_A_GAP   = 5,
    parameter int CLK_CLK_GAP = 6,
    parameter int Q_TIMEOUT   = 8,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_data,
    output logic [N_REQ-1:0] req_ready,
    output logic             a_out,
    output logic             clk_out,
    input  logic             q_in,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
    output logic             rsp_q,
    output logic             rsp_err,
    output logic             spurious,
    output logic             busy
);
    localparam int SAT  = (CLK_A_GAP > CLK_CLK_GAP) ? CLK_A_GAP : CLK_CLK_GAP;
    localparam int M1   = (INIT_WAIT > Q_TIMEOUT) ? INIT_WAIT : Q_TIMEOUT;
    localparam int CMAX = (M1 > A_CLK_GAP) ? M1 : A_CLK_GAP;
    localparam int CW   = $clog2(CMAX + 2);
    localparam int SW   = $clog2(SAT + 2);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_DATA, S_GAP, S_CLK, S_WAITQ, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   since_q, since_d;
    logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, win, idx;
    logic            data_q, data_d, a_q, a_d, c_q, c_d, rq_q, rq_d, spur_q, spur_d;
    logic            q_prev_q, q_edge;

    assign q_edge    = q_in ^ q_prev_q;
    assign a_out     = a_q;
    assign clk_out   = c_q;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_id    = id_q;
    assign rsp_q     = rq_q;
    assign rsp_err   = rsp_valid & (rq_q == data_q);
    assign spurious  = spur_q;
    assign busy      = state_q != S_IDLE;

    // Winner search: scanning from the far end leaves the nearest set bit at or after the pointer
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (req_valid[idx]) win = idx;
        end
    end

    // Next state; pulse toggles are registered on entry so the edge appears in the DATA/CLK cycle
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        data_d    = data_q;
        a_d       = a_q;
        c_d       = c_q;
        rq_d      = rq_q;
        req_ready = '0;
        case (state_q)
            S_INIT:  if (int'(cnt_q) >= INIT_WAIT - 1) state_d = S_IDLE;
            S_IDLE:  if (|req_valid && int'(since_q) >= CLK_A_GAP) begin
                         req_ready[win] = 1'b1;
                         id_d           = win;
                         data_d         = req_data[win];
                         a_d            = a_q ^ req_data[win];
                         ptr_d          = ID_W'((int'(win) + 1) % N_REQ);
                         state_d        = S_DATA;
                     end
            S_DATA:  state_d = S_GAP;
            S_GAP:   if (int'(cnt_q) >= A_CLK_GAP - 1 && int'(since_q) >= CLK_CLK_GAP) begin
                         c_d     = ~c_q;
                         state_d = S_CLK;
                     end
            S_CLK:   state_d = S_WAITQ;
            S_WAITQ: if (q_edge || int'(cnt_q) >= Q_TIMEOUT - 1) begin
                         rq_d    = q_edge;
                         state_d = S_RESP;
                     end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
        cnt_d   = (state_d != state_q) ? '0 : ((cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + CW'(1));
        since_d = (state_q == S_CLK) ? '0 : ((since_q == SW'(SAT)) ? since_q : since_q + SW'(1));
        spur_d  = spur_q | (q_edge & (state_q != S_WAITQ));
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            since_q  <= SW'(SAT);
            ptr_q    <= '0;
            id_q     <= '0;
            data_q   <= 1'b0;
            a_q      <= 1'b0;
            c_q      <= 1'b0;
            rq_q     <= 1'b0;
            spur_q   <= 1'b0;
            q_prev_q <= q_in;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            since_q  <= since_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            a_q      <= a_d;
            c_q      <= c_d;
            rq_q     <= rq_d;
            spur_q   <= spur_d;
            q_prev_q <= q_in;
        end
    end
endmodule

// File: tb/tb_mitll_not_sched.sv
// tb_mitll_not_sched: directed table-driven bench for the NOT-cell scheduler
module tb_mitll_not_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_data = '0;
    logic [3:0] req_ready;
    logic       a_out, clk_out, rsp_valid, rsp_q, rsp_err, spurious, busy;
    logic       q_in = 1'b0;
    logic [1:0] rsp_id;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int toggle_at = -1, stray_at = -1, last_c = -1000;
    int min_cc = 1000, min_ca = 1000, onehot_bad = 0;
    int grant_cyc = 0, a_cyc = 0, c_cyc = 0, rsp_cyc = 0;
    int n_a = 0, n_c = 0, n_rsp = 0, gid = 0;
    logic       a_prev = 1'b0, c_prev = 1'b0, q_mode = 1'b0, r_q = 1'b0, r_err = 1'b0;
    logic [1:0] r_id = '0;
    int gq[$];

    typedef struct {
        int   id;
        logic data;
        logic qm;
        int   r_off;
        logic eq;
        logic eerr;
    } row_t;
    row_t rows[4];

    mitll_not_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .a_out(a_out), .clk_out(clk_out), .q_in(q_in), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_err(rsp_err), .spurious(spurious), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cell model: cycle counter and q_in toggles requested by the monitor or the stimulus
    always @(posedge clk) begin
        cyc++;
        #1;
        if (cyc == toggle_at || cyc == stray_at) q_in = ~q_in;
    end

    // Monitor: records grants, pulse edges, responses and cell spacing
    always @(negedge clk) begin
        if (rst) begin
            a_prev = a_out;
            c_prev = clk_out;
            last_c = -1000;
        end else begin
            if (req_ready != '0) begin
                if (!$onehot(req_ready)) onehot_bad++;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
                gq.push_back(gid);
                grant_cyc = cyc;
            end
            if (a_out != a_prev) begin
                n_a++;
                a_cyc = cyc;
                if (cyc - last_c < min_ca) min_ca = cyc - last_c;
            end
            if (clk_out != c_prev) begin
                n_c++;
                c_cyc = cyc;
                if (cyc - last_c < min_cc) min_cc = cyc - last_c;
                last_c = cyc;
                if (q_mode) toggle_at = cyc + 2;
            end
            if (rsp_valid) begin
                n_rsp++;
                rsp_cyc = cyc;
                r_id = rsp_id;
                r_q = rsp_q;
                r_err = rsp_err;
            end
            a_prev = a_out;
            c_prev = clk_out;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pstep();
        @(posedge clk);
        #1;
    endtask

    task automatic init_check(input logic inject);
        int na0, nc0;
        na0 = n_a;
        nc0 = n_c;
        for (int k = 0; k < 8; k++) begin
            chk("init_busy", busy, 1);
            chk("init_no_ready", req_ready, 0);
            if (inject && k == 3) req_valid = '1;
            pstep();
        end
        chk("init_end_busy", busy, 0);
        chk("init_first_grant", req_ready, inject ? 1 : 0);
        chk("init_no_a_edge", n_a, na0);
        chk("init_no_clk_edge", n_c, nc0);
    endtask

    task automatic run_row(input row_t r);
        int na0, nc0, nr0, ng0, t;
        na0 = n_a;
        nc0 = n_c;
        nr0 = n_rsp;
        ng0 = gq.size();
        q_mode = r.qm;
        req_valid[r.id] = 1'b1;
        req_data[r.id] = r.data;
        for (int k = 0; k < 20 && gq.size() == ng0; k++) pstep();
        req_valid = '0;
        chk("row_grant_seen", gq.size(), ng0 + 1);
        chk("row_grant_id", gq.size() > 0 ? gq[$] : -1, r.id);
        t = grant_cyc;
        for (int k = 0; k < 30 && n_rsp == nr0; k++) pstep();
        chk("row_rsp_seen", n_rsp, nr0 + 1);
        chk("row_a_edges", n_a - na0, int'(r.data));
        if (r.data) chk("row_a_time", a_cyc - t, 1);
        chk("row_clk_edges", n_c - nc0, 1);
        chk("row_clk_time", c_cyc - t, 4);
        chk("row_rsp_time", rsp_cyc - t, r.r_off);
        chk("row_rsp_id", r_id, r.id);
        chk("row_rsp_q", r_q, r.eq);
        chk("row_rsp_err", r_err, r.eerr);
        chk("row_no_spurious", spurious, 0);
        repeat (12) pstep();
        chk("row_single_rsp", n_rsp, nr0 + 1);
    endtask

    initial begin
        int exp_rr[5];
        int nr0, nc0, ng0;
        exp_rr = '{0, 1, 2, 3, 0};
        rows[0] = '{2, 1'b0, 1'b1, 7, 1'b1, 1'b0};
        rows[1] = '{0, 1'b1, 1'b0, 13, 1'b0, 1'b0};
        rows[2] = '{1, 1'b1, 1'b1, 7, 1'b1, 1'b1};
        rows[3] = '{3, 1'b0, 1'b0, 13, 1'b0, 1'b1};

        repeat (3) pstep();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_q", rsp_q, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_spurious", spurious, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        init_check(1'b1);

        q_mode = 1'b1;
        for (int k = 0; k < 300 && gq.size() < 5; k++) pstep();
        req_valid = '0;
        chk("rr_grant_count", gq.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", i < gq.size() ? gq[i] : -1, exp_rr[i]);
        repeat (30) pstep();
        chk("rr_responses", n_rsp, 5);
        chk("rr_no_spurious", spurious, 0);
        chk("rr_clk_clk_spacing", (min_cc < 6) ? min_cc : 6, 6);
        chk("rr_clk_data_spacing", (min_ca < 5) ? min_ca : 5, 5);

        for (int i = 0; i < 4; i++) run_row(rows[i]);

        chk("stray_pre_spurious", spurious, 0);
        stray_at = cyc + 1;
        pstep();
        pstep();
        chk("stray_sets_spurious", spurious, 1);
        repeat (10) pstep();
        chk("stray_spurious_sticky", spurious, 1);
        chk("stray_stays_idle", busy, 0);

        nr0 = n_rsp;
        nc0 = n_c;
        ng0 = gq.size();
        q_mode = 1'b0;
        req_valid[2] = 1'b1;
        req_data[2] = 1'b1;
        for (int k = 0; k < 20 && gq.size() == ng0; k++) pstep();
        req_valid = '0;
        for (int k = 0; k < 20 && n_c == nc0; k++) pstep();
        chk("abort_clk_seen", n_c, nc0 + 1);
        pstep();
        rst = 1'b1;
        pstep();
        chk("abort_a_out", a_out, 0);
        chk("abort_clk_out", clk_out, 0);
        chk("abort_busy", busy, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_q", rsp_q, 0);
        chk("abort_spurious_cleared", spurious, 0);
        pstep();
        rst = 1'b0;
        init_check(1'b0);
        repeat (20) pstep();
        chk("abort_no_rsp", n_rsp, nr0);
        chk("grant_onehot", onehot_bad, 0);
        chk("end_clk_clk_spacing", (min_cc < 6) ? min_cc : 6, 6);
        chk("end_clk_data_spacing", (min_ca < 5) ? min_ca : 5, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mitll_not_sched.md
# mitll_not_sched

Scheduler that shares one clocked RSFQ NOT cell (`THmitll_NOT_v3p0`) among `N_REQ` requesters. It arbitrates requests round-robin and converts each accepted request into a correctly spaced data pulse and clock pulse on the cell. It then detects the output pulse and returns the inverted bit to the requester. It runs on the digital control clock and drives the cell's pulse inputs as toggle levels, where every edge is one SFQ pulse.

## Interface
- `N_REQ`, 4: number of requesters; `ID_W` = max(1, clog2(`N_REQ`)).
- `INIT_WAIT`, 8: cycles after reset before the first pulse is issued (cell settle time).
- `A_CLK_GAP`, 2: cycles from grant+1 (data pulse slot) to the clock pulse. Covers data-to-clock setup.
- `CLK_A_GAP`, 5: minimum cycles from a clock pulse to the next data pulse.
- `CLK_CLK_GAP`, 6: minimum cycles between two clock pulses.
- `Q_TIMEOUT`, 8: cycles after the clock pulse during which a `q_in` edge counts as output.
- `clk` in 1: control clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester request.
- `req_data` in `N_REQ`: per-requester input bit (1 = data pulse).
- `req_ready` out `N_REQ`: one-hot accept, high for exactly one cycle.
- `a_out` out 1: cell data input; each toggle is one pulse.
- `clk_out` out 1: cell clock input; each toggle is one pulse.
- `q_in` in 1: cell output level; each edge is one pulse.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_id` out `ID_W`: index of the requester being answered.
- `rsp_q` out 1: 1 if the cell produced an output pulse.
- `rsp_err` out 1: valid with `rsp_valid`; high when `rsp_q` != !data.
- `spurious` out 1: sticky flag; set by a `q_in` edge outside the WAIT_Q window. Cleared only by `rst`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values:
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_q`, `rsp_err`, `spurious` are 0.
  - `a_out` and `clk_out` are 0.
  - `busy` is 1; FSM is in INIT; round-robin pointer is 0.
  - `since_clk` saturates at max(`CLK_A_GAP`, `CLK_CLK_GAP`).
  - `q_prev` is loaded from `q_in`.
- A reset mid-operation aborts the current transaction with no response. Any `a_out`/`clk_out` edge caused by the reset is absorbed by INIT.
- `q_in` edge detection: `q_edge` = `q_in` ^ `q_prev`; `q_prev` is updated every cycle.
- FSM states:
  - INIT: count `INIT_WAIT` cycles, then go to IDLE.
  - IDLE: grant only if some `req_valid` is high and `since_clk` ≥ `CLK_A_GAP`.
    - Winner is the first set bit at or after the pointer, searching with wrap.
    - Pulse `req_ready[winner]`, latch id and data, set pointer to winner+1 mod `N_REQ`.
    - Go to DATA.
  - DATA (1 cycle): toggle `a_out` if the latched data is 1; otherwise no pulse. Go to GAP.
  - GAP: count `A_CLK_GAP` cycles. Stay while `since_clk` < `CLK_CLK_GAP`. Then go to CLK.
  - CLK (1 cycle): toggle `clk_out`, clear `since_clk`. Go to WAIT_Q.
  - WAIT_Q: go to RESP on the first `q_edge` (`rsp_q`=1), or after `Q_TIMEOUT` cycles without one (`rsp_q`=0).
  - RESP (1 cycle): `rsp_valid`=1, `rsp_err` = (`rsp_q` == data). Go to IDLE.
- A `q_edge` in any state other than WAIT_Q sets `spurious`. This includes a second edge after the one already counted.
- `req_valid` is sampled only in IDLE. Requesters hold `req_valid`/`req_data` until `req_ready`; dropping `req_valid` earlier withdraws the request.
- There is one transaction in flight at a time; no queuing.

## Timing
- Reference point: grant at cycle T (`req_ready` high in T).
- Data pulse at T+1.
- Clock pulse at T+2+`A_CLK_GAP`, later only if the `CLK_CLK_GAP` stall applies.
- A `q_edge` seen at cycle C gives `rsp_valid` at C+1.
- On timeout, `rsp_valid` occurs at clock cycle + `Q_TIMEOUT` + 1.
- With defaults and an immediately available requester, the earliest next grant is the cycle after RESP. The `CLK_A_GAP` guard is already met by then whenever the WAIT_Q+RESP span ≥ `CLK_A_GAP`.
- Guaranteed spacing at the cell, in cycles:
  - data to clock ≥ `A_CLK_GAP`+1;
  - clock to data ≥ `CLK_A_GAP`;
  - clock to clock ≥ `CLK_CLK_GAP`.
- Simultaneous requests: exactly one grant per IDLE visit, decided by the pointer.
- Requests arriving during INIT are held off; the first grant is the cycle after INIT ends.

## Test plan
- Reset, then hold `q_in` constant.
  - No `a_out`/`clk_out` edge for 8 cycles.
  - `busy`=1 for those cycles, then 0.
- Requester 2 sends data=0; model toggles `q_in` 2 cycles after the `clk_out` edge.
  - `a_out` has no edge.
  - `clk_out` edge at T+4.
  - `rsp_valid` with id=2, q=1, err=0.
- Requester 0 sends data=1; model gives no `q_in` edge.
  - `a_out` edge at T+1, `clk_out` edge at T+4.
  - `rsp_valid` at T+13 with q=0, err=0.
- All 4 request continuously.
  - Grants go 0,1,2,3,0.
  - Every `clk_out` edge pair is ≥6 cycles apart.
  - Every `clk_out`→`a_out` spacing is ≥5.
- Data=1 but the model toggles `q_in`.
  - `rsp_q`=1, `rsp_err`=1.
  - A later stray `q_in` edge in IDLE sets `spurious`, which stays set until `rst`.
- Assert `rst` during WAIT_Q.
  - No `rsp_valid` for the aborted transaction.
  - `a_out`/`clk_out` are 0, and INIT repeats.
